sync_filter: RTL and testbench
==============================

# sync_filter

Multi-channel clock-domain-crossing input conditioner for asynchronous control and status lines such as GPIO straps, lock indicators and external triggers. Each of WIDTH channels passes through a SYNC_STAGES-deep flip-flop chain and then a per-channel stability filter that rejects pulses shorter than FILTER_CYCLES clocks. Optionally, the block emits one-cycle rise and fall strobes. It sits at the boundary of the destination clock domain, in front of CSR capture logic and event counters.

## Interface
- WIDTH, 1: number of independent channels.
- INIT, {WIDTH{1'b0}}: per-channel reset value of the synchroniser chain and of s_out.
- SYNC_STAGES, 2: synchroniser depth; must be ≥2.
- FILTER_CYCLES, 4: consecutive differing cycles required to accept a new level; must be ≥1.
- clk  in  1  destination-domain clock; single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- a_in  in  WIDTH  asynchronous inputs; no timing relation to clk.
- s_out  out  WIDTH  filtered, synchronised level.
- s_rise  out  WIDTH  one-cycle strobe when s_out goes 0→1.
- s_fall  out  WIDTH  one-cycle strobe when s_out goes 1→0.

## Operation
- Per channel: shift register sreg[SYNC_STAGES-1:0] with attribute ASYNC_REG="TRUE"; sreg[0] captures a_in; ssync = sreg[SYNC_STAGES-1].
- Per-channel counter cnt, width max(1, $clog2(FILTER_CYCLES)). Counts saturate at FILTER_CYCLES-1 and never wrap.
- Behaviour on each clk edge, per channel, when rst=0:
  - ssync == s_out: cnt ← 0.
  - ssync != s_out and cnt < FILTER_CYCLES-1: cnt ← cnt+1.
  - ssync != s_out and cnt == FILTER_CYCLES-1: s_out ← ssync, cnt ← 0, and strobe s_rise or s_fall according to the new value.
- A difference that returns to s_out before acceptance clears cnt. Partial counts never carry over to the next difference.
- Channels are fully independent. Simultaneous events on different channels each produce their own strobe in the same cycle.
- FILTER_CYCLES=1 disables filtering: any synchronised change is accepted on the next edge.
- Reset values: sreg = INIT per channel, s_out = INIT, cnt = 0, s_rise = 0, s_fall = 0.
- Reset applied mid-count: count is discarded and s_out returns to INIT on that edge, with no strobe.
- After reset release with a_in != INIT, the channel filters normally and then strobes once on acceptance.

## Timing
- All outputs are registered. There is no combinational path from a_in.
- Latency: a level that a_in presents stably before edge 1 appears on s_out after edge SYNC_STAGES+FILTER_CYCLES.
- s_rise/s_fall go high in the same cycle s_out first shows the new value, and last exactly one cycle.
- The minimum accepted pulse is FILTER_CYCLES cycles at ssync. Shorter pulses produce no s_out change and no strobe.
- Back-to-back toggles: the minimum spacing between successive strobes on one channel is FILTER_CYCLES cycles.

## Configuration
- SYNC_FILTER_EDGES_EN defined: edge strobe registers are built and behave as described above.
- SYNC_FILTER_EDGES_EN undefined: no strobe registers are built; s_rise and s_fall are tied to 0. s_out behaviour is identical in both builds.

## Test plan
- Reset: WIDTH=4, INIT=4'b1010, rst held for 3 cycles with a_in=4'b0000. Required: s_out=4'b1010 and strobes 0 during reset. Four cycles after release (SYNC_STAGES=2, FILTER_CYCLES=2), s_out=0000 with s_fall=4'b1010 for one cycle.
- Latency: SYNC_STAGES=2, FILTER_CYCLES=4. a_in[0] goes 0→1 before edge 1. Required: s_out[0]=1 and s_rise[0]=1 after edge 6, and s_rise[0]=0 after edge 7.
- Glitch rejection: a_in[0] pulses high for 3 cycles with FILTER_CYCLES=4. Required: s_out stays 0 and no strobe. A following 4-cycle pulse must give s_out=1 for exactly 4 cycles, with one s_rise and one s_fall.
- Count restart: pattern 1,1,1,0,1,1,1,1 at ssync with FILTER_CYCLES=4. Required: acceptance only at the end of the final four ones, with no carry-over from the first run.
- Parallel channels: WIDTH=8, all a_in toggle in the same cycle. Required: all s_out bits update and all strobes fire in the same cycle.
- Build without SYNC_FILTER_EDGES_EN, rerunning the latency test. Required: s_out timing is identical and s_rise/s_fall stay 0 throughout.

Source files
------------

// File: rtl/sync_filter.sv
// Multi-channel CDC input conditioner: SYNC_STAGES flip-flop synchroniser followed by a
// per-channel stability filter. Define SYNC_FILTER_EDGES_EN to build the rise/fall strobes.
module sync_filter #(
  parameter int              WIDTH         = 1,
  parameter logic [WIDTH-1:0] INIT         = '0,
  parameter int              SYNC_STAGES   = 2,
  parameter int              FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] s_rise,
  output logic [WIDTH-1:0] s_fall
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  // Stage 0 is the metastability-capture flop; the last stage is the safe synchronised level.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic [WIDTH-1:0] ssync;
  logic [WIDTH-1:0] s_out_q, s_out_d;
  logic [WIDTH-1:0] accept_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  assign ssync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= INIT;
      end
    end else begin
      sync_q[0] <= a_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // A differing level must persist FILTER_CYCLES edges; any return to s_out restarts the count.
  always_comb begin
    s_out_d  = s_out_q;
    accept_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (ssync[i] != s_out_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          accept_d[i] = 1'b1;
          s_out_d[i]  = ssync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_out_q <= INIT;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s_out_q <= s_out_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign s_out = s_out_q;

`ifdef SYNC_FILTER_EDGES_EN
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  assign rise_d = accept_d & ssync;
  assign fall_d = accept_d & ~ssync;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign s_rise = rise_q;
  assign s_fall = fall_q;
`else
  logic unused_accept;
  assign unused_accept = ^accept_d;
  assign s_rise = '0;
  assign s_fall = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: three instances covering reset/INIT, the FILTER_CYCLES=4
// filter corners on an 8-bit bus, and the unfiltered FILTER_CYCLES=1 / 3-stage case.
module tb_sync_filter;

`ifdef SYNC_FILTER_EDGES_EN
  localparam logic EDGES = 1'b1;
`else
  localparam logic EDGES = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [3:0] a_a, out_a, rise_a, fall_a;
  logic [7:0] a_b, out_b, rise_b, fall_b;
  logic       a_c, out_c, rise_c, fall_c;

  sync_filter #(.WIDTH(4), .INIT(4'b1010), .SYNC_STAGES(2), .FILTER_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .a_in(a_a), .s_out(out_a), .s_rise(rise_a), .s_fall(fall_a)
  );

  sync_filter #(.WIDTH(8), .INIT(8'h00), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst_b), .a_in(a_b), .s_out(out_b), .s_rise(rise_b), .s_fall(fall_b)
  );

  sync_filter #(.WIDTH(1), .INIT(1'b0), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst_c), .a_in(a_c), .s_out(out_c), .s_rise(rise_c), .s_fall(fall_c)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Strobes are expected only when the strobe registers are built.
  function automatic logic [7:0] stb(input logic [7:0] v);
    return EDGES ? v : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f);
    check({tag, "_out"},  {4'h0, out_a},  {4'h0, o});
    check({tag, "_rise"}, {4'h0, rise_a}, stb({4'h0, r}));
    check({tag, "_fall"}, {4'h0, fall_a}, stb({4'h0, f}));
  endtask

  task automatic check_c(input string tag, input logic o, input logic r, input logic f);
    check({tag, "_out"},  {7'h0, out_c},  {7'h0, o});
    check({tag, "_rise"}, {7'h0, rise_c}, stb({7'h0, r}));
    check({tag, "_fall"}, {7'h0, fall_c}, stb({7'h0, f}));
  endtask

  // ---------------- dut_b vector table ----------------
  // Each row drives a for n edges; the outputs must equal out/rise/fall after each of them.
  typedef struct {
    logic [7:0] a;
    int         n;
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] a, input int n, input logic [7:0] o,
                              input logic [7:0] r, input logic [7:0] f);
    vec_t v;
    v.a = a; v.n = n; v.out = o; v.rise = r; v.fall = f;
    vecs.push_back(v);
  endfunction

  initial begin
    // latency: a[0] rises before edge 1, accepted after edge 6
    add(8'h01, 5, 8'h00, 8'h00, 8'h00);
    add(8'h01, 1, 8'h01, 8'h01, 8'h00);
    add(8'h01, 1, 8'h01, 8'h00, 8'h00);
    // return to 0
    add(8'h00, 5, 8'h01, 8'h00, 8'h00);
    add(8'h00, 1, 8'h00, 8'h00, 8'h01);
    add(8'h00, 2, 8'h00, 8'h00, 8'h00);
    // 3-cycle glitch rejected
    add(8'h01, 3, 8'h00, 8'h00, 8'h00);
    add(8'h00, 6, 8'h00, 8'h00, 8'h00);
    // 4-cycle pulse: s_out high for exactly 4 cycles
    add(8'h01, 4, 8'h00, 8'h00, 8'h00);
    add(8'h00, 1, 8'h00, 8'h00, 8'h00);
    add(8'h00, 1, 8'h01, 8'h01, 8'h00);
    add(8'h00, 3, 8'h01, 8'h00, 8'h00);
    add(8'h00, 1, 8'h00, 8'h00, 8'h01);
    add(8'h00, 2, 8'h00, 8'h00, 8'h00);
    // count restart: 1,1,1,0,1,1,1,1...
    add(8'h01, 3, 8'h00, 8'h00, 8'h00);
    add(8'h00, 1, 8'h00, 8'h00, 8'h00);
    add(8'h01, 5, 8'h00, 8'h00, 8'h00);
    add(8'h01, 1, 8'h01, 8'h01, 8'h00);
    add(8'h01, 1, 8'h01, 8'h00, 8'h00);
    // all channels toggle together
    add(8'hFE, 5, 8'h01, 8'h00, 8'h00);
    add(8'hFE, 1, 8'hFE, 8'hFE, 8'h01);
    add(8'hFE, 2, 8'hFE, 8'h00, 8'h00);
    add(8'h01, 5, 8'hFE, 8'h00, 8'h00);
    add(8'h01, 1, 8'h01, 8'h01, 8'hFE);
    add(8'h01, 1, 8'h01, 8'h00, 8'h00);
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    a_a = 4'h0; a_b = 8'h00; a_c = 1'b0;

    // reset held 3 cycles with a_in = 0000: INIT visible, no strobes
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("rst_hold", 4'b1010, 4'b0000, 4'b0000);
    end
    check("rst_b_out", out_b, 8'h00);
    check_c("rst_c", 1'b0, 1'b0, 1'b0);

    // release: fall strobe on INIT-high bits four edges later
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_a("rel_wait", 4'b1010, 4'b0000, 4'b0000);
    end
    tick();
    check_a("rel_accept", 4'b0000, 4'b0000, 4'b1010);
    tick();
    check_a("rel_after", 4'b0000, 4'b0000, 4'b0000);

    // reset mid-count discards the count with no strobe
    a_a = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("mid_cnt", 4'b0000, 4'b0000, 4'b0000);
    end
    rst_a = 1'b1;
    tick();
    check_a("mid_rst", 4'b1010, 4'b0000, 4'b0000);
    // release with a_in != INIT: filter normally, strobe once
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("mid_rel_wait", 4'b1010, 4'b0000, 4'b0000);
    end
    tick();
    check_a("mid_rel_acc", 4'b1111, 4'b0101, 4'b0000);
    tick();
    check_a("mid_rel_after", 4'b1111, 4'b0000, 4'b0000);

    // dut_b table
    foreach (vecs[v]) begin
      a_b = vecs[v].a;
      for (int k = 0; k < vecs[v].n; k++) begin
        tick();
        check($sformatf("vec%0d_out", v),  out_b,  vecs[v].out);
        check($sformatf("vec%0d_rise", v), rise_b, stb(vecs[v].rise));
        check($sformatf("vec%0d_fall", v), fall_b, stb(vecs[v].fall));
      end
    end

    // dut_c: FILTER_CYCLES=1, SYNC_STAGES=3 -> latency 4, single-cycle pulses pass
    a_c = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_c("c_lat_wait", 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_c("c_lat_acc", 1'b1, 1'b1, 1'b0);
    tick();
    check_c("c_lat_after", 1'b1, 1'b0, 1'b0);
    a_c = 1'b0;
    tick();
    check_c("c_pulse_w6", 1'b1, 1'b0, 1'b0);
    a_c = 1'b1;
    tick();
    check_c("c_pulse_w7", 1'b1, 1'b0, 1'b0);
    tick();
    check_c("c_pulse_w8", 1'b1, 1'b0, 1'b0);
    tick();
    check_c("c_pulse_low", 1'b0, 1'b0, 1'b1);
    tick();
    check_c("c_pulse_high", 1'b1, 1'b1, 1'b0);
    tick();
    check_c("c_pulse_end", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
